processor_status_register: RTL and testbench
============================================

Name: processor_status_register

Overview:
- Holds the 6502 processor status register P (N V - B D I Z C).
- Sits directly downstream of the ALU and decimal adjust adder. Consumes the adjusted result sb_ac and the ALU flags acr/avr.
- Applies flag updates through a one-stage hold pipeline, which mirrors the ALU output latch.
- Drives the D flag back to the decimal adjust control. Provides P for PHP/BRK/IRQ pushes.

Parameters:
- RESET_P, 8'h04, value of the stored flags after reset. Default is I=1, all others 0. Bits 5 and 4 are ignored.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- alu_result  in  8  decimal-adjusted ALU result (sb_ac)
- alu_acr  in  1  ALU carry out
- alu_avr  in  1  ALU overflow out
- alu_latch  in  1  capture alu_result/acr/avr and the ld_* selection into the hold stage
- ld_nvzc  in  1  with alu_latch: update N,V,Z,C (ADC/SBC)
- ld_nzc  in  1  with alu_latch: update N,Z,C (shifts, CMP)
- ld_nz  in  1  with alu_latch: update N,Z (logic ops, loads, INC/DEC)
- ld_bit  in  1  with alu_latch: N<=db_in[7], V<=db_in[6] from the captured db_in; Z from alu_result (BIT)
- db_in  in  8  data bus; captured with alu_latch for ld_bit; used directly for ld_p_db
- ld_p_db  in  1  load N,V,D,I,Z,C from db_in (PLP/RTI), immediate
- set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v  in  1 each  direct flag control, immediate
- brk_push  in  1  selects the B bit of p_out (1 for PHP/BRK, 0 for IRQ/NMI)
- p_out  out  8  {N,V,1,brk_push,D,I,Z,C}
- flag_n, flag_v, flag_d, flag_i, flag_z, flag_c  out  1 each  stored flags
- pend_valid  out  1  hold stage contains an unapplied update

Behaviour:
- Reset (async, rst=1):
  - Stored flags take RESET_P; pend_valid=0; hold registers cleared.
  - p_out=8'h24 with brk_push=0 and the default RESET_P.
  - Reset mid-pipeline discards the pending update.
- Hold stage, edge k with alu_latch=1:
  - Capture alu_result, alu_acr, alu_avr, db_in[7:6] and the one-hot update type.
  - pend_valid<=1 if any ld_* is set; otherwise pend_valid<=0.
- More than one ld_* at capture: priority is ld_nvzc > ld_nzc > ld_bit > ld_nz.
- ld_* without alu_latch has no effect.
- Apply, edge k+1 with pend_valid=1:
  - Z <= (held result == 0).
  - N <= held result[7], except ld_bit, which uses held db[7].
  - C <= held acr (nvzc/nzc).
  - V <= held avr (nvzc) or held db[6] (bit).
- Latency: flags reflect an ALU operation exactly one edge after capture. They are unchanged on the capture edge itself.
- Back-to-back captures on every edge are legal. Each is applied on the following edge, giving throughput of 1 per cycle.
- alu_latch=0 at edge k+1: pend_valid<=0 after the apply.
- Priority at a single edge (highest first): rst > ld_p_db > direct set/clr > pending apply.
  - ld_p_db overrides all six flags. A pending update applying on the same edge is discarded.
  - Direct set/clr overrides the pending update only for the bit it touches. Other pending bits still apply.
  - set_x and clr_x together: clr wins.
- ld_p_db ignores db_in[5:4]; B and bit 5 are never stored.
- p_out, flag_* and pend_valid are registered or pure decodes of registered state, plus brk_push for p_out[4]. There is no combinational path from the alu_* inputs.

Test Plan:
- Reset: assert rst asynchronously between edges -> p_out=8'h24, flag_i=1, pend_valid=0 immediately, with no clock needed.
- ADC pipeline: alu_latch+ld_nvzc with result=8'h80, acr=0, avr=1 at edge k -> edge k unchanged; after edge k+1 N=1, V=1, Z=0, C=0, p_out=8'hE4 (I=1).
- Back-to-back captures:
  - Edge k: ld_nz, result 8'h00.
  - Edge k+1: ld_nzc, result 8'h7F, acr=1.
  - Required: Z=1 after k+1; after k+2 Z=0, N=0, C=1, pend_valid=0.
- BIT: db_in=8'hC0, result=8'h00, alu_latch+ld_bit -> after the next edge N=1, V=1, Z=1, C unchanged.
- Collision:
  - Pending ld_nzc (acr=1) applies on the same edge as clr_c -> C=0, N/Z still updated.
  - Repeat with ld_p_db=1, db_in=8'h3F -> flags = N0 V0 D1 I1 Z1 C1, pending discarded.
- Reset mid-pipeline: capture ld_nvzc, assert rst before the apply edge, release -> flags = RESET_P, no late update.

Source files
------------

// File: rtl/processor_status_register_if.sv
// Bus between the CPU datapath/control and the 6502 status register P.
// The master drives ALU results and flag controls; the slave returns P and the flags.
interface processor_status_register_if;
  logic [7:0] alu_result;
  logic       alu_acr;
  logic       alu_avr;
  logic       alu_latch;
  logic       ld_nvzc;
  logic       ld_nzc;
  logic       ld_nz;
  logic       ld_bit;
  logic [7:0] db_in;
  logic       ld_p_db;
  logic       set_c;
  logic       clr_c;
  logic       set_d;
  logic       clr_d;
  logic       set_i;
  logic       clr_i;
  logic       clr_v;
  logic       brk_push;
  logic [7:0] p_out;
  logic       flag_n;
  logic       flag_v;
  logic       flag_d;
  logic       flag_i;
  logic       flag_z;
  logic       flag_c;
  logic       pend_valid;

  modport master (
    output alu_result, alu_acr, alu_avr, alu_latch,
    output ld_nvzc, ld_nzc, ld_nz, ld_bit, db_in, ld_p_db,
    output set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v, brk_push,
    input  p_out, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, pend_valid
  );

  modport slave (
    input  alu_result, alu_acr, alu_avr, alu_latch,
    input  ld_nvzc, ld_nzc, ld_nz, ld_bit, db_in, ld_p_db,
    input  set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v, brk_push,
    output p_out, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, pend_valid
  );
endinterface

// File: rtl/processor_status_register.sv
// 6502 status register P with a one-stage hold pipeline mirroring the ALU output latch.
// Flag updates captured with alu_latch are applied on the following edge.
module processor_status_register #(
  parameter logic [7:0] RESET_P = 8'h04
) (
  input logic                          clk,
  input logic                          rst,
  processor_status_register_if.slave   psr_if
);

  typedef enum logic [1:0] {
    UPD_NVZC = 2'd0,
    UPD_NZC  = 2'd1,
    UPD_BIT  = 2'd2,
    UPD_NZ   = 2'd3
  } upd_e;

  logic [7:0] res_q, res_d;
  logic       acr_q, acr_d;
  logic       avr_q, avr_d;
  logic [1:0] db_q, db_d;
  upd_e       typ_q, typ_d;
  logic       pend_q, pend_d;

  logic n_q, n_d, v_q, v_d, d_q, d_d, i_q, i_d, z_q, z_d, c_q, c_d;

  // Hold stage capture and priority encoding of the update type.
  always_comb begin
    res_d  = res_q;
    acr_d  = acr_q;
    avr_d  = avr_q;
    db_d   = db_q;
    typ_d  = typ_q;
    pend_d = 1'b0;
    if (psr_if.alu_latch) begin
      res_d  = psr_if.alu_result;
      acr_d  = psr_if.alu_acr;
      avr_d  = psr_if.alu_avr;
      db_d   = psr_if.db_in[7:6];
      pend_d = psr_if.ld_nvzc | psr_if.ld_nzc | psr_if.ld_bit | psr_if.ld_nz;
      if (psr_if.ld_nvzc) begin
        typ_d = UPD_NVZC;
      end else if (psr_if.ld_nzc) begin
        typ_d = UPD_NZC;
      end else if (psr_if.ld_bit) begin
        typ_d = UPD_BIT;
      end else begin
        typ_d = UPD_NZ;
      end
    end else begin
      pend_d = 1'b0;
    end
  end

  // Flag next state: pending apply, then per-bit direct controls, then PLP/RTI load.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (pend_q) begin
      z_d = (res_q == 8'h00);
      case (typ_q)
        UPD_NVZC: begin
          n_d = res_q[7];
          v_d = avr_q;
          c_d = acr_q;
        end
        UPD_NZC: begin
          n_d = res_q[7];
          c_d = acr_q;
        end
        UPD_BIT: begin
          n_d = db_q[1];
          v_d = db_q[0];
        end
        UPD_NZ: begin
          n_d = res_q[7];
        end
        default: begin
          n_d = n_q;
        end
      endcase
    end else begin
      z_d = z_q;
    end

    // clr wins over set when both are asserted
    if (psr_if.clr_c) begin
      c_d = 1'b0;
    end else if (psr_if.set_c) begin
      c_d = 1'b1;
    end else begin
      c_d = c_d;
    end
    if (psr_if.clr_d) begin
      d_d = 1'b0;
    end else if (psr_if.set_d) begin
      d_d = 1'b1;
    end else begin
      d_d = d_d;
    end
    if (psr_if.clr_i) begin
      i_d = 1'b0;
    end else if (psr_if.set_i) begin
      i_d = 1'b1;
    end else begin
      i_d = i_d;
    end
    if (psr_if.clr_v) begin
      v_d = 1'b0;
    end else begin
      v_d = v_d;
    end

    if (psr_if.ld_p_db) begin
      n_d = psr_if.db_in[7];
      v_d = psr_if.db_in[6];
      d_d = psr_if.db_in[3];
      i_d = psr_if.db_in[2];
      z_d = psr_if.db_in[1];
      c_d = psr_if.db_in[0];
    end else begin
      n_d = n_d;
    end
  end

  // State registers; reset drops any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= 8'h00;
      acr_q  <= 1'b0;
      avr_q  <= 1'b0;
      db_q   <= 2'b00;
      typ_q  <= UPD_NVZC;
      pend_q <= 1'b0;
      n_q    <= RESET_P[7];
      v_q    <= RESET_P[6];
      d_q    <= RESET_P[3];
      i_q    <= RESET_P[2];
      z_q    <= RESET_P[1];
      c_q    <= RESET_P[0];
    end else begin
      res_q  <= res_d;
      acr_q  <= acr_d;
      avr_q  <= avr_d;
      db_q   <= db_d;
      typ_q  <= typ_d;
      pend_q <= pend_d;
      n_q    <= n_d;
      v_q    <= v_d;
      d_q    <= d_d;
      i_q    <= i_d;
      z_q    <= z_d;
      c_q    <= c_d;
    end
  end

  assign psr_if.p_out      = {n_q, v_q, 1'b1, psr_if.brk_push, d_q, i_q, z_q, c_q};
  assign psr_if.flag_n     = n_q;
  assign psr_if.flag_v     = v_q;
  assign psr_if.flag_d     = d_q;
  assign psr_if.flag_i     = i_q;
  assign psr_if.flag_z     = z_q;
  assign psr_if.flag_c     = c_q;
  assign psr_if.pend_valid = pend_q;

endmodule

// File: tb/tb_processor_status_register.sv
// Directed self-checking bench for processor_status_register.
module tb_processor_status_register;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  processor_status_register_if bus ();

  processor_status_register #(.RESET_P(8'h04)) dut (
    .clk    (clk),
    .rst    (rst),
    .psr_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_result = 8'h00; bus.alu_acr = 1'b0; bus.alu_avr = 1'b0;
    bus.alu_latch = 1'b0; bus.ld_nvzc = 1'b0; bus.ld_nzc = 1'b0;
    bus.ld_nz = 1'b0; bus.ld_bit = 1'b0; bus.db_in = 8'h00; bus.ld_p_db = 1'b0;
    bus.set_c = 1'b0; bus.clr_c = 1'b0; bus.set_d = 1'b0; bus.clr_d = 1'b0;
    bus.set_i = 1'b0; bus.clr_i = 1'b0; bus.clr_v = 1'b0; bus.brk_push = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.set_c = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.p_out !== 8'h25) begin errors++; $display("FAIL reset_setc p_out=%h exp=25", bus.p_out); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.p_out !== 8'h24) begin errors++; $display("FAIL reset_async p_out=%h exp=24", bus.p_out); end
    checks++;
    if (bus.flag_i !== 1'b1 || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags i=%b pend=%b exp i=1 pend=0", bus.flag_i, bus.pend_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_adc();
    bus.alu_latch = 1'b1; bus.ld_nvzc = 1'b1;
    bus.alu_result = 8'h80; bus.alu_acr = 1'b0; bus.alu_avr = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.p_out !== 8'h24 || bus.pend_valid !== 1'b1) begin
      errors++; $display("FAIL adc_capture p_out=%h pend=%b exp 24/1", bus.p_out, bus.pend_valid);
    end
    tick();
    checks++;
    if (bus.p_out !== 8'hE4 || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL adc_apply p_out=%h pend=%b exp E4/0", bus.p_out, bus.pend_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.alu_latch = 1'b1; bus.ld_nz = 1'b1; bus.alu_result = 8'h00;
    tick();
    bus.ld_nz = 1'b0; bus.ld_nzc = 1'b1; bus.alu_result = 8'h7F; bus.alu_acr = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.flag_z !== 1'b1 || bus.flag_n !== 1'b0 || bus.pend_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first z=%b n=%b pend=%b exp 1/0/1", bus.flag_z, bus.flag_n, bus.pend_valid);
    end
    tick();
    checks++;
    if (bus.p_out !== 8'h65 || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second p_out=%h pend=%b exp 65/0", bus.p_out, bus.pend_valid);
    end
  endtask

  task automatic test_bit();
    bus.alu_latch = 1'b1; bus.ld_bit = 1'b1; bus.db_in = 8'hC0; bus.alu_result = 8'h00;
    tick();
    idle();
    tick();
    checks++;
    if (bus.p_out !== 8'hE7) begin errors++; $display("FAIL bit_apply p_out=%h exp E7", bus.p_out); end
  endtask

  task automatic test_collision();
    bus.alu_latch = 1'b1; bus.ld_nzc = 1'b1; bus.alu_result = 8'h81; bus.alu_acr = 1'b1;
    tick();
    idle();
    bus.clr_c = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.p_out !== 8'hE4) begin errors++; $display("FAIL coll_clrc p_out=%h exp E4", bus.p_out); end
    bus.alu_latch = 1'b1; bus.ld_nvzc = 1'b1; bus.alu_result = 8'h80; bus.alu_avr = 1'b1;
    tick();
    idle();
    bus.ld_p_db = 1'b1; bus.db_in = 8'h3F;
    tick();
    idle();
    checks++;
    if (bus.p_out !== 8'h2F || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL coll_plp p_out=%h pend=%b exp 2F/0", bus.p_out, bus.pend_valid);
    end
    tick();
    checks++;
    if (bus.p_out !== 8'h2F) begin errors++; $display("FAIL coll_noleak p_out=%h exp 2F", bus.p_out); end
  endtask

  task automatic test_priority();
    bus.set_i = 1'b1; bus.clr_i = 1'b1;
    bus.ld_nz = 1'b1; bus.alu_result = 8'h80;
    tick();
    tick();
    idle();
    checks++;
    if (bus.p_out !== 8'h2B || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL prio_setclr_noload p_out=%h pend=%b exp 2B/0", bus.p_out, bus.pend_valid);
    end
    bus.alu_latch = 1'b1; bus.ld_nvzc = 1'b1; bus.ld_bit = 1'b1;
    bus.alu_result = 8'h00; bus.alu_acr = 1'b1; bus.alu_avr = 1'b0; bus.db_in = 8'hC0;
    tick();
    idle();
    tick();
    checks++;
    if (bus.flag_n !== 1'b0 || bus.flag_v !== 1'b0 || bus.flag_z !== 1'b1 || bus.flag_c !== 1'b1) begin
      errors++; $display("FAIL prio_nvzc_bit nvzc=%b%b%b%b exp 0011", bus.flag_n, bus.flag_v, bus.flag_z, bus.flag_c);
    end
    bus.alu_latch = 1'b1; bus.ld_nzc = 1'b1; bus.ld_nz = 1'b1; bus.alu_result = 8'h01;
    tick();
    idle();
    tick();
    checks++;
    if (bus.p_out !== 8'h28) begin errors++; $display("FAIL prio_nzc_nz p_out=%h exp 28", bus.p_out); end
    bus.brk_push = 1'b1;
    #1;
    checks++;
    if (bus.p_out !== 8'h38) begin errors++; $display("FAIL brk_push p_out=%h exp 38", bus.p_out); end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.alu_latch = 1'b1; bus.ld_nvzc = 1'b1;
    bus.alu_result = 8'h80; bus.alu_acr = 1'b1; bus.alu_avr = 1'b1;
    tick();
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.p_out !== 8'h24 || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_async p_out=%h pend=%b exp 24/0", bus.p_out, bus.pend_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.p_out !== 8'h24 || bus.pend_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_noapply p_out=%h pend=%b exp 24/0", bus.p_out, bus.pend_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_adc();
    test_back_to_back();
    test_bit();
    test_collision();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
